// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//
// Purpose:
//   Stall, flush and freeze controller for a 5-stage pipelined core. It takes
//   the load-use hazard flag, the EX-stage branch-taken flag and the MEM-stage
//   memory-busy flag, and drives the PC write enable, IF/ID write and flush,
//   ID/EX bubble insertion and the back-end freeze.
//   A memory-wait FSM (RUN / MEM_WAIT / TRAP) watches how long the memory
//   stays busy. If it stays busy for too long, a watchdog traps the core.
//   Only reset leaves the trap.
//
// Optional feature:
//   STALL_PERF_CNT_EN - when defined, enables the three performance counters.
//   When it is undefined, the counter ports are tied to zero and no counter
//   flops exist.
//
// Parameters:
//   MAX_MEM_WAIT - longest legal run of consecutive mem_busy cycles (1..255)
//   CNT_W        - width of the performance counters
//
// Ports:
//   clk             in   core clock; all state changes on the rising edge
//   rst             in   synchronous active-high reset
//   hazard_detected in   load-use hazard (ID vs EX)
//   branch_taken    in   branch/jump resolved taken in EX
//   mem_busy        in   data memory not ready
//   pc_write        out  PC register write enable
//   if_id_write     out  IF/ID register write enable
//   if_id_flush     out  load a NOP into IF/ID
//   id_ex_bubble    out  zero the control bits entering ID/EX
//   pipe_freeze     out  hold ID/EX, EX/MEM and MEM/WB
//   mem_timeout     out  watchdog trap flag (held until reset)
//   ctrl_state      out  registered FSM state: 0 RUN, 1 MEM_WAIT, 2 TRAP
//   load_use_cnt    out  load-use stall cycles
//   flush_cnt       out  branch flush cycles
//   mem_wait_cnt    out  memory freeze cycles outside TRAP
module pipeline_stall_ctrl #(
    parameter int unsigned MAX_MEM_WAIT = 15,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TRAP     = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT = 8'(MAX_MEM_WAIT);

    state_t     state;
    logic [7:0] wait_cnt;   // consecutive busy cycles seen so far

    assign ctrl_state = state;

    // Output decode. RUN and a released MEM_WAIT share the same priority
    // decode. A busy memory always wins, because the MEM stage cannot retire.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        mem_timeout  = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (state != ST_RUN && state != ST_MEM_WAIT) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
            mem_timeout = 1'b1;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
        end else if (branch_taken) begin
            // The instruction in IF/ID is wrong-path, so any hazard it raises is moot.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (hazard_detected) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= 8'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_busy) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_busy) begin
                        // Reaching the limit while still busy means this is
                        // the (MAX+1)-th consecutive busy cycle.
                        if (wait_cnt == MAX_WAIT) begin
                            state <= ST_TRAP;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end else begin
                        state    <= ST_RUN;
                        wait_cnt <= 8'd0;
                    end
                end
                ST_TRAP: begin
                    state <= ST_TRAP;
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= 8'd0;
                end
            endcase
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic             active;
    logic             lu_evt;
    logic             fl_evt;
    logic             mw_evt;
    logic [CNT_W-1:0] load_use_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] mem_wait_q;

    // These events match the decode above. They are re-derived from the inputs
    // so that they do not depend on the reset override of the outputs.
    assign active = (state == ST_RUN) || (state == ST_MEM_WAIT);
    assign mw_evt = active && mem_busy;
    assign fl_evt = active && !mem_busy && branch_taken;
    assign lu_evt = active && !mem_busy && !branch_taken && hazard_detected;

    always_ff @(posedge clk) begin
        if (rst) begin
            load_use_q <= '0;
            flush_q    <= '0;
            mem_wait_q <= '0;
        end else begin
            if (lu_evt) load_use_q <= load_use_q + CNT_W'(1);
            if (fl_evt) flush_q    <= flush_q + CNT_W'(1);
            if (mw_evt) mem_wait_q <= mem_wait_q + CNT_W'(1);
        end
    end

    assign load_use_cnt = load_use_q;
    assign flush_cnt    = flush_q;
    assign mem_wait_cnt = mem_wait_q;
`else
    assign load_use_cnt = '0;
    assign flush_cnt    = '0;
    assign mem_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Testbench for pipeline_stall_ctrl. A behavioural model tracks two things:
// the run of consecutive busy cycles and a trapped flag. A compare process
// checks every output on each falling edge. Directed scenarios also pin
// hand-computed literal values shortly after each rising edge.
module tb_pipeline_stall_ctrl;

    localparam int MAXW = 15;
    localparam int CW   = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hz = 1'b0, br = 1'b0, mb = 1'b0;
    logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout;
    logic [1:0]    ctrl_state;
    logic [CW-1:0] load_use_cnt, flush_cnt, mem_wait_cnt;

    int tests = 0;
    int fails = 0;
    bit perf_on;

    pipeline_stall_ctrl #(.MAX_MEM_WAIT(MAXW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .hazard_detected(hz), .branch_taken(br), .mem_busy(mb),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
        .ctrl_state(ctrl_state), .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt),
        .mem_wait_cnt(mem_wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model state, as it stands after the next rising edge.
    int            busy_run = 0;
    bit            trapped  = 1'b0;
    bit            waiting  = 1'b0;
    logic [CW-1:0] m_lu = '0, m_fl = '0, m_mw = '0;

    always @(negedge clk) begin
        logic [5:0] e;   // expected {pc_write, if_id_write, flush, bubble, freeze, timeout}
        logic [1:0] es;
        es = trapped ? 2'd2 : (waiting ? 2'd1 : 2'd0);
        if (rst)           e = 6'b001100;
        else if (trapped)  e = 6'b000011;
        else if (mb)       e = 6'b000010;
        else if (br)       e = 6'b111100;
        else if (hz)       e = 6'b000100;
        else               e = 6'b110000;
        check("m_outputs", {26'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble,
                            pipe_freeze, mem_timeout}, {26'd0, e});
        check("m_ctrl_state", {30'd0, ctrl_state}, {30'd0, es});
        check("m_load_use_cnt", load_use_cnt, perf_on ? m_lu : '0);
        check("m_flush_cnt", flush_cnt, perf_on ? m_fl : '0);
        check("m_mem_wait_cnt", mem_wait_cnt, perf_on ? m_mw : '0);
        // Advance the model across the coming edge.
        if (rst) begin
            busy_run = 0; trapped = 1'b0; waiting = 1'b0;
            m_lu = '0; m_fl = '0; m_mw = '0;
        end else if (!trapped) begin
            if (mb) begin
                busy_run++;
                m_mw++;
                waiting = 1'b1;
                if (busy_run > MAXW) trapped = 1'b1;
            end else begin
                busy_run = 0;
                waiting = 1'b0;
                if (br)      m_fl++;
                else if (hz) m_lu++;
            end
        end
    end

    // Apply one cycle of inputs just after a rising edge.
    task automatic step(input logic r, input logic h, input logic b, input logic m);
        @(posedge clk);
        #1;
        rst = r; hz = h; br = b; mb = m;
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_pc_write", {31'd0, pc_write}, 32'd0);
        check("rst_flush_bubble", {30'd0, if_id_flush, id_ex_bubble}, 32'd3);
        check("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    endtask

    initial begin
`ifdef STALL_PERF_CNT_EN
        perf_on = 1'b1;
`else
        perf_on = 1'b0;
`endif
        do_reset();
        // Idle after reset.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("idle_pc_ifid", {30'd0, pc_write, if_id_write}, 32'd3);
        check("idle_flush_bubble", {30'd0, if_id_flush, id_ex_bubble}, 32'd0);
        check("idle_state", {30'd0, ctrl_state}, 32'd0);

        // Single load-use stall.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("lu_stall", {29'd0, pc_write, if_id_write, id_ex_bubble}, 32'b001);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("lu_after", {29'd0, pc_write, if_id_write, id_ex_bubble}, 32'b110);
        check("lu_cnt", load_use_cnt, perf_on ? 32'd1 : 32'd0);

        // Branch together with a hazard: the branch wins.
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("br_hz", {29'd0, pc_write, if_id_flush, id_ex_bubble}, 32'b111);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("br_hz_cnts", {flush_cnt[15:0], load_use_cnt[15:0]},
              perf_on ? 32'h0001_0000 : 32'd0);

        // Fifteen busy cycles with a branch held: legal, and the flush fires on release.
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            if (i == 2 || i == 15) begin
                check("mw_freeze", {30'd0, pipe_freeze, pc_write}, 32'b10);
                check("mw_state", {30'd0, ctrl_state}, 32'd1);
            end
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("mw_release", {29'd0, pc_write, if_id_flush, mem_timeout}, 32'b110);
        check("mw_release_state", {30'd0, ctrl_state}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("mw_cnt", mem_wait_cnt, perf_on ? 32'd15 : 32'd0);
        check("mw_no_trap", {30'd0, ctrl_state}, 32'd0);

        // Seventeen busy cycles: the trap appears on cycle 17.
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 16) check("tr_c16", {30'd0, mem_timeout, ctrl_state[1]}, 32'd0);
        end
        check("tr_c17", {29'd0, mem_timeout, ctrl_state}, 32'b110);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("tr_hold", {28'd0, pc_write, pipe_freeze, mem_timeout, if_id_flush}, 32'b0110);
        check("tr_hold_state", {30'd0, ctrl_state}, 32'd2);
        check("tr_mw_cnt", mem_wait_cnt, perf_on ? 32'd16 : 32'd0);

        // A reset pulse leaves the trap.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("tr_exit", {29'd0, mem_timeout, ctrl_state}, 32'd0);
        check("tr_exit_cnts", load_use_cnt | flush_cnt | mem_wait_cnt, 32'd0);

        // Mixed traffic checked by the model only.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 97) == 0, $urandom % 2, ($urandom % 4) == 0,
                 ($urandom % 5) == 0 || (i >= 200 && i < 220));
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
